uart_rx_os16: RTL and testbench

//  16x-oversampling UART receiver; sits directly downstream of the baud divider, consuming its uart_clk.

---
 rtl/uart_rx_os16.sv | 168 ++++++++++++++++
 tb/tb_uart_rx_os16.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os16.sv
// 16x-oversampling 8N1 UART receiver with a valid/ready byte output, clocked on sys_clk.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_os16 #(
    parameter int OS_RATE   = 16,
    parameter int DATA_BITS = 8
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 uart_clk,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 overrun
);

    // state  | meaning
    // IDLE   | line idle, waiting for a low sample on a tick
    // START  | counting to mid start bit to confirm it is not a glitch
    // DATA   | sampling data bits mid-bit, LSB first
    // PARITY | sampling the even-parity bit (parity build only)
    // STOP   | sampling the stop bit, then deliver or flag framing error
    // BREAK  | line held low after a framing error; wait for it to go high

    localparam int OSW = $clog2(OS_RATE);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam logic [OSW-1:0] OS_MID   = OSW'(OS_RATE / 2 - 1);
    localparam logic [OSW-1:0] OS_LAST  = OSW'(OS_RATE - 1);
    localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, BREAK
`ifdef UART_RX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t               state;
    logic [OSW-1:0]       os_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 uart_clk_d;
    logic                 rxd_m;
    logic                 rxd_s;
    logic                 tick;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad;
`endif

    assign tick = uart_clk & ~uart_clk_d;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state      <= IDLE;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            uart_clk_d <= 1'b1;
            rxd_m      <= 1'b1;
            rxd_s      <= 1'b1;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            par_bad    <= 1'b0;
`endif
        end else begin
            uart_clk_d <= uart_clk;
            rxd_m      <= rxd;
            rxd_s      <= rxd_m;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;

            if (tick) begin
                case (state)
                    IDLE: begin
                        if (!rxd_s) begin
                            state  <= START;
                            os_cnt <= '0;
                        end
                    end
                    START: begin
                        if (os_cnt == OS_MID) begin
                            os_cnt  <= '0;
                            bit_cnt <= '0;
                            state   <= rxd_s ? IDLE : DATA;
                        end else begin
                            os_cnt <= os_cnt + OSW'(1);
                        end
                    end
                    DATA: begin
                        if (os_cnt == OS_LAST) begin
                            shreg   <= {rxd_s, shreg[DATA_BITS-1:1]};
                            os_cnt  <= '0;
                            bit_cnt <= bit_cnt + BW'(1);
                            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end else begin
                            os_cnt <= os_cnt + OSW'(1);
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (os_cnt == OS_LAST) begin
                            par_bad <= (^shreg) ^ rxd_s;
                            os_cnt  <= '0;
                            state   <= STOP;
                        end else begin
                            os_cnt <= os_cnt + OSW'(1);
                        end
                    end
`endif
                    STOP: begin
                        if (os_cnt == OS_LAST) begin
                            os_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                            parity_err <= par_bad;
`endif
                            if (!rxd_s) begin
                                frame_err <= 1'b1;
                                state     <= BREAK;
                            end else begin
                                state <= IDLE;
`ifdef UART_RX_PARITY_EN
                                if (!par_bad) begin
`else
                                begin
`endif
                                    // A held, unaccepted byte wins; the new one is dropped.
                                    if (rx_valid && !rx_ready) begin
                                        overrun <= 1'b1;
                                    end else begin
                                        rx_data  <= shreg;
                                        rx_valid <= 1'b1;
                                    end
                                end
                            end
                        end else begin
                            os_cnt <= os_cnt + OSW'(1);
                        end
                    end
                    BREAK: begin
                        if (rxd_s)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed self-checking bench for uart_rx_os16; uart_clk ticks every 4 sys_clk so one bit is 64 cycles.
// Define UART_RX_PARITY_EN for both files to exercise the parity build.
module tb_uart_rx_os16;

    localparam int TICK_CYC = 4;
    localparam int BIT_CYC  = 16 * TICK_CYC;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_CYC = 11 * BIT_CYC;
`else
    localparam int FRAME_CYC = 10 * BIT_CYC;
`endif

    logic       sys_clk  = 1'b0;
    logic       rst      = 1'b1;
    logic       uart_clk = 1'b0;
    logic       rxd      = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    logic       par_flip = 1'b0;
    int         perr_cyc = 0;
`endif

    int         n_checks  = 0;
    int         n_errors  = 0;
    int         valid_cyc = 0;
    int         ferr_cyc  = 0;
    int         ovr_cyc   = 0;
    logic [7:0] last_data = 8'h00;
    int         v0, f0, o0;

    uart_rx_os16 #(.OS_RATE(16), .DATA_BITS(8)) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .uart_clk  (uart_clk),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .overrun   (overrun)
    );

    initial forever #5 sys_clk = ~sys_clk;

    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge sys_clk);
            div = div + 1;
            uart_clk = ((div % TICK_CYC) >= TICK_CYC / 2);
        end
    end

    // Event counters sampled on the falling edge, away from DUT updates.
    always @(negedge sys_clk) begin
        if (rx_valid) begin
            valid_cyc <= valid_cyc + 1;
            last_data <= rx_data;
        end
        if (frame_err) ferr_cyc <= ferr_cyc + 1;
        if (overrun)   ovr_cyc  <= ovr_cyc + 1;
`ifdef UART_RX_PARITY_EN
        if (parity_err) perr_cyc <= perr_cyc + 1;
`endif
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Leaves the line at the stop-bit level on return.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        wait_cyc(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_cyc(BIT_CYC);
        end
`ifdef UART_RX_PARITY_EN
        rxd = (^b) ^ par_flip;
        wait_cyc(BIT_CYC);
`endif
        rxd = stop_bit;
        wait_cyc(BIT_CYC);
    endtask

    task automatic snap();
        v0 = valid_cyc;
        f0 = ferr_cyc;
        o0 = ovr_cyc;
    endtask

    initial begin
        logic seen;
        seen = 1'b0;

        // Reset state
        @(negedge sys_clk);
        rst = 1'b1;
        wait_cyc(5);
        check_eq("reset rx_valid", 32'(rx_valid), 0);
        check_eq("reset rx_data", 32'(rx_data), 0);
        check_eq("reset frame_err", 32'(frame_err), 0);
        check_eq("reset overrun", 32'(overrun), 0);
        rst = 1'b0;
        wait_cyc(BIT_CYC);

        // 1: clean 0x55 with rx_ready held high
        rx_ready = 1'b1;
        snap();
        send_frame(8'h55, 1'b1);
        wait_cyc(16);
        check_eq("t1 valid cycles", 32'(valid_cyc - v0), 1);
        check_eq("t1 rx_data", 32'(last_data), 32'h55);
        check_eq("t1 frame_err", 32'(ferr_cyc - f0), 0);
        check_eq("t1 overrun", 32'(ovr_cyc - o0), 0);

        // 2: 3-tick glitch is rejected, next frame still decodes
        snap();
        rxd = 1'b0;
        wait_cyc(3 * TICK_CYC);
        rxd = 1'b1;
        wait_cyc(2 * BIT_CYC);
        check_eq("t2 glitch valid", 32'(valid_cyc - v0), 0);
        check_eq("t2 glitch frame_err", 32'(ferr_cyc - f0), 0);
        send_frame(8'h0F, 1'b1);
        wait_cyc(16);
        check_eq("t2 after glitch data", 32'(last_data), 32'h0F);

        // 3: low stop bit then long low line: one frame_err, no retrigger
        snap();
        send_frame(8'hA3, 1'b0);
        wait_cyc(12 * BIT_CYC);
        check_eq("t3 frame_err pulses", 32'(ferr_cyc - f0), 1);
        check_eq("t3 no valid", 32'(valid_cyc - v0), 0);
        rxd = 1'b1;
        wait_cyc(2 * BIT_CYC);
        send_frame(8'h5A, 1'b1);
        wait_cyc(16);
        check_eq("t3 recover data", 32'(last_data), 32'h5A);
        check_eq("t3 recover valid", 32'(valid_cyc - v0), 1);

        // 4: two frames with rx_ready low -> overrun, first byte kept
        rx_ready = 1'b0;
        snap();
        send_frame(8'h12, 1'b1);
        send_frame(8'h34, 1'b1);
        wait_cyc(16);
        check_eq("t4 rx_valid held", 32'(rx_valid), 1);
        check_eq("t4 rx_data kept", 32'(rx_data), 32'h12);
        check_eq("t4 overrun pulses", 32'(ovr_cyc - o0), 1);
        rx_ready = 1'b1;
        @(negedge sys_clk);
        check_eq("t4 valid cleared", 32'(rx_valid), 0);
        rx_ready = 1'b0;
        wait_cyc(4);

        // 5: accept on exactly the cycle the second byte is delivered
        snap();
        fork
            begin
                send_frame(8'hAB, 1'b1);
                send_frame(8'h34, 1'b1);
            end
            begin
                for (int i = 0; i < 3 * FRAME_CYC; i++) begin
                    @(negedge sys_clk);
                    if (rx_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                if (seen) begin
                    wait_cyc(FRAME_CYC - 1);
                    rx_ready = 1'b1;
                    @(negedge sys_clk);
                    rx_ready = 1'b0;
                end
            end
        join
        wait_cyc(16);
        check_eq("t5 first valid seen", 32'(seen), 1);
        check_eq("t5 rx_valid stays", 32'(rx_valid), 1);
        check_eq("t5 rx_data new", 32'(rx_data), 32'h34);
        check_eq("t5 no overrun", 32'(ovr_cyc - o0), 0);

        // 6: reset mid-DATA abandons the frame, then 0xC3 decodes
        rx_ready = 1'b1;
        wait_cyc(4);
        snap();
        rxd = 1'b0;
        wait_cyc(BIT_CYC);
        rxd = 1'b1;
        wait_cyc(BIT_CYC);
        rxd = 1'b0;
        wait_cyc(BIT_CYC);
        rxd = 1'b1;
        wait_cyc(20);
        rst = 1'b1;
        wait_cyc(3);
        check_eq("t6 reset rx_valid", 32'(rx_valid), 0);
        check_eq("t6 reset rx_data", 32'(rx_data), 0);
        rst = 1'b0;
        wait_cyc(2 * BIT_CYC);
        check_eq("t6 no partial output", 32'(valid_cyc - v0), 0);
        send_frame(8'hC3, 1'b1);
        wait_cyc(16);
        check_eq("t6 rx_data", 32'(last_data), 32'hC3);
        check_eq("t6 valid cycles", 32'(valid_cyc - v0), 1);
        check_eq("t6 frame_err", 32'(ferr_cyc - f0), 0);

`ifdef UART_RX_PARITY_EN
        // Odd parity on 0xC3 -> parity_err, byte discarded
        snap();
        begin
            int p0;
            p0 = perr_cyc;
            par_flip = 1'b1;
            send_frame(8'hC3, 1'b1);
            par_flip = 1'b0;
            wait_cyc(16);
            check_eq("par parity_err pulses", 32'(perr_cyc - p0), 1);
            check_eq("par no valid", 32'(valid_cyc - v0), 0);
            check_eq("par frame_err", 32'(ferr_cyc - f0), 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
